// File: rtl/instr_rom_resp_pkg.sv
// Shared types and defaults for the instruction ROM responder and its byte loader.
// Holds FSM encodings plus a helper that zero-pads a partial word.
package instr_rom_resp_pkg;

  localparam int unsigned DEF_DEPTH_W   = 1024;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    RUN   = 2'd3
  } state_t;

  // Bytes not yet received stay zero, so a partial word pads its upper lanes with zeros.
  function automatic logic [31:0] pad_word(input logic [23:0] part);
    return {8'h00, part};
  endfunction

endpackage

// File: rtl/instr_rom_resp_ld_packer.sv
// Byte->word assembler: emits word_vld in the same cycle as the 4th byte, or on flush
// with a partial word; no backpressure, the caller gates byte_vld.
module instr_rom_resp_ld_packer
  import instr_rom_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  input  logic        flush,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [1:0]  byte_cnt;
  logic [23:0] part;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= 2'd0;
      part     <= 24'h0;
    end else if (clr || flush) begin
      byte_cnt <= 2'd0;
      part     <= 24'h0;
    end else if (byte_vld) begin
      byte_cnt <= byte_cnt + 2'd1;
      case (byte_cnt)
        2'd0:    part[7:0]   <= byte_dat;
        2'd1:    part[15:8]  <= byte_dat;
        2'd2:    part[23:16] <= byte_dat;
        default: part        <= 24'h0;
      endcase
    end
  end

  always_comb begin
    word_vld = 1'b0;
    word_dat = pad_word(part);
    if (byte_vld && byte_cnt == 2'd3) begin
      word_vld = 1'b1;
      word_dat = {byte_dat, part};
    end else if (flush && byte_cnt != 2'd0) begin
      word_vld = 1'b1;
    end
  end

endmodule

// File: rtl/instr_rom_resp.sv
// Instruction memory: zero-latency combinational fetch, loaded once per boot over a byte port.
// Loader has no backpressure; bytes past the end are dropped and flagged in ld_err_o.
module instr_rom_resp
  import instr_rom_resp_pkg::*;
#(
  parameter int unsigned DEPTH_W   = DEF_DEPTH_W,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc_i,
  output logic [31:0] instr_o,
  output logic        instr_vld_o,
  output logic        fetch_err_o,
  input  logic        ld_start_i,
  input  logic        ld_vld_i,
  input  logic [7:0]  ld_data_i,
  input  logic        ld_last_i,
  output logic        ld_busy_o,
  output logic        ld_done_o,
  output logic        ld_err_o
);

  localparam int unsigned AW = (DEPTH_W > 1) ? $clog2(DEPTH_W) : 1;
  localparam logic [AW:0]   PTR_FULL = (AW + 1)'(DEPTH_W);
  localparam logic [31:0]   SPAN     = 32'(4 * DEPTH_W);

  state_t      state, state_nxt;
  logic [AW:0] wr_ptr;
  logic        full;
  logic        restart, byte_acc, byte_drop, flush;
  logic        word_vld;
  logic [31:0] word_dat;
  logic        mem_we;

  logic [31:0] mem [DEPTH_W];

  assign full   = (wr_ptr == PTR_FULL);
  assign mem_we = word_vld && !full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= BOOT;
    else        state <= state_nxt;
  end

  // A start pulse in the same cycle as a byte wins: the byte belongs to the abandoned image.
  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    byte_acc  = 1'b0;
    byte_drop = 1'b0;
    flush     = 1'b0;
    case (state)
      BOOT: begin
        if (ld_start_i) begin
          state_nxt = LOAD;
          restart   = 1'b1;
        end
      end
      LOAD: begin
        if (ld_start_i) begin
          restart = 1'b1;
        end else if (ld_vld_i) begin
          byte_acc  = !full;
          byte_drop = full;
          if (ld_last_i) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        flush     = 1'b1;
        state_nxt = RUN;
      end
      RUN: begin
        if (ld_start_i) begin
          state_nxt = LOAD;
          restart   = 1'b1;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  instr_rom_resp_ld_packer u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (restart),
    .byte_vld (byte_acc),
    .byte_dat (ld_data_i),
    .flush    (flush),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      ld_err_o <= 1'b0;
    end else begin
      if (restart)     wr_ptr <= '0;
      else if (mem_we) wr_ptr <= wr_ptr + 1'b1;
      if (restart)        ld_err_o <= 1'b0;
      else if (byte_drop) ld_err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_ptr[AW-1:0]] <= word_dat;
  end

  assign ld_busy_o = (state == LOAD);
  assign ld_done_o = (state == FLUSH);

  logic [31:0] off;
  logic        misaligned, below, beyond;

  assign off         = pc_i - BASE_ADDR;
  assign misaligned  = |pc_i[1:0];
  assign below       = pc_i < BASE_ADDR;
  assign beyond      = off >= SPAN;
  assign fetch_err_o = misaligned | below | beyond;
  assign instr_vld_o = (state == RUN) && !fetch_err_o;
  assign instr_o     = instr_vld_o ? mem[off[AW+1:2]] : NOP_INSTR;

endmodule
